// File: rtl/led_mode_if.sv
// Key inputs and registered LED-control outputs of the waterfall mode controller.
interface led_mode_if;
  logic       key_mode_n;
  logic       key_pause_n;
  logic       S;
  logic       S1;
  logic       S0;
  logic [7:0] D;
  logic       stop_n;
  logic [1:0] mode;

  modport master (output key_mode_n, key_pause_n,
                  input  S, S1, S0, D, stop_n, mode);
  modport slave  (input  key_mode_n, key_pause_n,
                  output S, S1, S0, D, stop_n, mode);
endinterface

// File: rtl/led_mode_ctrl.sv
// Debounced mode/pause keys driving the waterfall select, shift-register mode and counter enable.
// state | meaning:  DEC decoder path | SHL load then shift left | SHR load then shift right | HOLD register frozen

module led_key_deb #(
  parameter int unsigned DEB_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int unsigned CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CW-1:0] TC = CW'(DEB_CNT - 1);

  logic [1:0]    sync_q;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      level  <= 1'b1;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == TC) begin
        level <= sync_q[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Pulse in the cycle the new low level is accepted, so the FSM acts on the same edge.
  assign press = (sync_q[1] != level) && (cnt == TC) && !sync_q[1];
endmodule

module led_mode_ctrl #(
  parameter int unsigned DEB_CNT  = 1_000_000,
  parameter int unsigned LOAD_CNT = 50_000_000
) (
  input logic       clk,
  input logic       rst_n,
  led_mode_if.slave bus
);
  localparam logic [1:0] ST_DEC  = 2'd0;
  localparam logic [1:0] ST_SHL  = 2'd1;
  localparam logic [1:0] ST_SHR  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  localparam int unsigned LW = (LOAD_CNT > 1) ? $clog2(LOAD_CNT) : 1;

  logic          ev_mode;
  logic          ev_pause;
  logic [1:0]    state, state_nx;
  logic          paused, paused_nx;
  logic          in_load, in_load_nx;
  logic [LW-1:0] load_cnt, load_cnt_nx;
  logic [1:0]    sel_nx;
  logic [7:0]    d_nx;

  led_key_deb #(.DEB_CNT(DEB_CNT)) u_deb_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_mode_n),
    .press (ev_mode)
  );

  led_key_deb #(.DEB_CNT(DEB_CNT)) u_deb_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_pause_n),
    .press (ev_pause)
  );

  // A mode press wins over pause, clears paused and aborts any running load phase.
  always_comb begin
    state_nx    = state;
    paused_nx   = paused;
    in_load_nx  = in_load;
    load_cnt_nx = load_cnt;
    if (ev_mode) begin
      state_nx    = state + 2'd1;
      paused_nx   = 1'b0;
      in_load_nx  = (state_nx == ST_SHL) || (state_nx == ST_SHR);
      load_cnt_nx = in_load_nx ? LW'(LOAD_CNT - 1) : '0;
    end else begin
      if (ev_pause) paused_nx = !paused;
      if (in_load) begin
        if (load_cnt == '0) in_load_nx  = 1'b0;
        else                load_cnt_nx = load_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    sel_nx = SEL_HOLD;
    d_nx   = 8'h00;
    case (state_nx)
      ST_SHL: begin
        d_nx   = 8'h01;
        sel_nx = in_load_nx ? SEL_LOAD : (paused_nx ? SEL_HOLD : SEL_LEFT);
      end
      ST_SHR: begin
        d_nx   = 8'h80;
        sel_nx = in_load_nx ? SEL_LOAD : (paused_nx ? SEL_HOLD : SEL_RIGHT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_DEC;
      paused           <= 1'b0;
      in_load          <= 1'b0;
      load_cnt         <= '0;
      bus.S            <= 1'b1;
      {bus.S1, bus.S0} <= SEL_HOLD;
      bus.D            <= 8'h00;
      bus.stop_n       <= 1'b1;
    end else begin
      state            <= state_nx;
      paused           <= paused_nx;
      in_load          <= in_load_nx;
      load_cnt         <= load_cnt_nx;
      bus.S            <= (state_nx == ST_DEC);
      {bus.S1, bus.S0} <= sel_nx;
      bus.D            <= d_nx;
      bus.stop_n       <= !((state_nx == ST_DEC) && paused_nx);
    end
  end

  assign bus.mode = state;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: vector table, load-abort taps and random keys against a cycle model.
module tb_led_mode_ctrl;
  localparam int DEB0 = 4, LOAD0 = 8, DEB1 = 2, LOAD1 = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  led_mode_if bus0();
  led_mode_if bus1();

  led_mode_ctrl #(.DEB_CNT(DEB0), .LOAD_CNT(LOAD0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  led_mode_ctrl #(.DEB_CNT(DEB1), .LOAD_CNT(LOAD1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model per instance [i] and key [k]: 0 = mode, 1 = pause.
  logic m_s1  [2][2];
  logic m_s2  [2][2];
  logic m_acc [2][2];
  int   m_run [2][2];
  int   m_mode [2];
  bit   m_paused [2];
  int   m_left [2];

  typedef struct packed {
    logic       rst;
    logic       km;
    logic       kp;
    logic [7:0] n;
    logic [1:0] mode;
    logic       s;
    logic [1:0] sel;
    logic [7:0] d;
    logic       stop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic km, input logic kp, input int n,
                              input int md, input logic s, input logic [1:0] sel,
                              input logic [7:0] d, input logic stop);
    vec_t v;
    v.rst = r; v.km = km; v.kp = kp; v.n = 8'(n); v.mode = 2'(md);
    v.s = s; v.sel = sel; v.d = d; v.stop = stop;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input int i, input logic r, input logic km, input logic kp);
    logic raw [2];
    bit   ev  [2];
    int   deb, ld;
    raw[0] = km; raw[1] = kp;
    deb = (i == 0) ? DEB0 : DEB1;
    ld  = (i == 0) ? LOAD0 : LOAD1;
    if (!r) begin
      for (int k = 0; k < 2; k++) begin
        m_s1[i][k] = 1'b1; m_s2[i][k] = 1'b1; m_acc[i][k] = 1'b1; m_run[i][k] = 0;
      end
      m_mode[i] = 0; m_paused[i] = 0; m_left[i] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        ev[k] = 0;
        if (m_s2[i][k] != m_acc[i][k]) begin
          m_run[i][k]++;
          if (m_run[i][k] == deb) begin
            m_acc[i][k] = m_s2[i][k];
            m_run[i][k] = 0;
            ev[k] = (m_s2[i][k] == 1'b0);
          end
        end else begin
          m_run[i][k] = 0;
        end
        m_s2[i][k] = m_s1[i][k];
        m_s1[i][k] = raw[k];
      end
      if (ev[0]) begin
        m_mode[i]   = (m_mode[i] + 1) % 4;
        m_paused[i] = 0;
        m_left[i]   = (m_mode[i] == 1 || m_mode[i] == 2) ? ld : 0;
      end else begin
        if (ev[1]) m_paused[i] = !m_paused[i];
        if (m_left[i] > 0) m_left[i]--;
      end
    end
  endtask

  task automatic check_model(input int i, input logic [1:0] md, input logic s,
                             input logic [1:0] sel, input logic [7:0] d, input logic stop);
    int e_sel, e_d;
    e_sel = 0; e_d = 0;
    if (m_mode[i] == 1 || m_mode[i] == 2) begin
      e_d = (m_mode[i] == 1) ? 8'h01 : 8'h80;
      if (m_left[i] > 0)    e_sel = 3;
      else if (m_paused[i]) e_sel = 0;
      else                  e_sel = (m_mode[i] == 1) ? 2 : 1;
    end
    chk($sformatf("dut%0d.mode", i), md, m_mode[i]);
    chk($sformatf("dut%0d.S", i), s, (m_mode[i] == 0) ? 1 : 0);
    chk($sformatf("dut%0d.S1S0", i), sel, e_sel);
    chk($sformatf("dut%0d.D", i), d, e_d);
    chk($sformatf("dut%0d.stop_n", i), stop, (m_mode[i] == 0 && m_paused[i]) ? 0 : 1);
  endtask

  task automatic cyc(input logic r, input logic km0, input logic kp0,
                     input logic km1, input logic kp1);
    rst_n = r;
    bus0.key_mode_n = km0; bus0.key_pause_n = kp0;
    bus1.key_mode_n = km1; bus1.key_pause_n = kp1;
    @(posedge clk);
    model_step(0, r, km0, kp0);
    model_step(1, r, km1, kp1);
    #1;
    check_model(0, bus0.mode, bus0.S, {bus0.S1, bus0.S0}, bus0.D, bus0.stop_n);
    check_model(1, bus1.mode, bus1.S, {bus1.S1, bus1.S0}, bus1.D, bus1.stop_n);
  endtask

  logic rk [4];

  initial begin
    rst_n = 1'b0;
    bus0.key_mode_n = 1'b1; bus0.key_pause_n = 1'b1;
    bus1.key_mode_n = 1'b1; bus1.key_pause_n = 1'b1;

    //                rst km kp  n  mode S  sel    D     stop
    tbl.push_back(mk(0, 1, 1,  2, 0, 1, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 1, 1,  3, 0, 1, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 0, 1,  5, 0, 1, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 0, 1,  1, 1, 0, 2'b11, 8'h01, 1));
    tbl.push_back(mk(1, 0, 1,  4, 1, 0, 2'b11, 8'h01, 1));
    tbl.push_back(mk(1, 1, 1,  3, 1, 0, 2'b11, 8'h01, 1));
    tbl.push_back(mk(1, 1, 1,  1, 1, 0, 2'b10, 8'h01, 1));
    tbl.push_back(mk(1, 1, 1,  6, 1, 0, 2'b10, 8'h01, 1));
    tbl.push_back(mk(1, 1, 0,  6, 1, 0, 2'b00, 8'h01, 1));
    tbl.push_back(mk(1, 1, 1,  6, 1, 0, 2'b00, 8'h01, 1));
    tbl.push_back(mk(1, 0, 1,  6, 2, 0, 2'b11, 8'h80, 1));
    tbl.push_back(mk(1, 1, 1, 10, 2, 0, 2'b01, 8'h80, 1));
    tbl.push_back(mk(1, 1, 0,  6, 2, 0, 2'b00, 8'h80, 1));
    tbl.push_back(mk(1, 1, 1,  6, 2, 0, 2'b00, 8'h80, 1));
    tbl.push_back(mk(1, 0, 1,  6, 3, 0, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 1, 1,  6, 3, 0, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 1, 0,  6, 3, 0, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 1, 1,  6, 3, 0, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 0, 1,  6, 0, 1, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 1, 1,  6, 0, 1, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 1, 0,  6, 0, 1, 2'b00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 1,  6, 0, 1, 2'b00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 0,  6, 0, 1, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 1, 1,  6, 0, 1, 2'b00, 8'h00, 1));
    // glitches of 3 and 4 cycles: only the second is accepted
    tbl.push_back(mk(1, 0, 1,  3, 0, 1, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 1, 1,  8, 0, 1, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 0, 1,  4, 0, 1, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 1, 1,  1, 0, 1, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 1, 1,  1, 1, 0, 2'b11, 8'h01, 1));
    tbl.push_back(mk(1, 1, 1,  8, 1, 0, 2'b10, 8'h01, 1));
    // bounce 0,1,0,1 then stable low
    tbl.push_back(mk(1, 0, 1,  1, 1, 0, 2'b10, 8'h01, 1));
    tbl.push_back(mk(1, 1, 1,  1, 1, 0, 2'b10, 8'h01, 1));
    tbl.push_back(mk(1, 0, 1,  1, 1, 0, 2'b10, 8'h01, 1));
    tbl.push_back(mk(1, 1, 1,  1, 1, 0, 2'b10, 8'h01, 1));
    tbl.push_back(mk(1, 0, 1,  5, 1, 0, 2'b10, 8'h01, 1));
    tbl.push_back(mk(1, 0, 1,  1, 2, 0, 2'b11, 8'h80, 1));
    tbl.push_back(mk(1, 1, 1, 10, 2, 0, 2'b01, 8'h80, 1));
    tbl.push_back(mk(1, 0, 1,  6, 3, 0, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 1, 1,  6, 3, 0, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 0, 1,  6, 0, 1, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 1, 1,  6, 0, 1, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 0, 1,  6, 1, 0, 2'b11, 8'h01, 1));
    tbl.push_back(mk(1, 1, 1, 10, 1, 0, 2'b10, 8'h01, 1));
    // mode and pause accepted on the same edge in SHL
    tbl.push_back(mk(1, 0, 0,  5, 1, 0, 2'b10, 8'h01, 1));
    tbl.push_back(mk(1, 0, 0,  1, 2, 0, 2'b11, 8'h80, 1));
    tbl.push_back(mk(1, 1, 1, 10, 2, 0, 2'b01, 8'h80, 1));
    tbl.push_back(mk(1, 0, 1,  6, 3, 0, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 1, 1,  6, 3, 0, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 0, 1,  6, 0, 1, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 1, 1,  6, 0, 1, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 0, 1,  6, 1, 0, 2'b11, 8'h01, 1));
    tbl.push_back(mk(1, 1, 1,  2, 1, 0, 2'b11, 8'h01, 1));
    tbl.push_back(mk(0, 1, 1,  1, 0, 1, 2'b00, 8'h00, 1));
    tbl.push_back(mk(1, 1, 1, 12, 0, 1, 2'b00, 8'h00, 1));

    foreach (tbl[j]) begin
      for (int c = 0; c < int'(tbl[j].n); c++) cyc(tbl[j].rst, tbl[j].km, tbl[j].kp, 1'b1, 1'b1);
      chk($sformatf("tbl%0d.mode", j), bus0.mode, tbl[j].mode);
      chk($sformatf("tbl%0d.S", j), bus0.S, tbl[j].s);
      chk($sformatf("tbl%0d.S1S0", j), {bus0.S1, bus0.S0}, tbl[j].sel);
      chk($sformatf("tbl%0d.D", j), bus0.D, tbl[j].d);
      chk($sformatf("tbl%0d.stop_n", j), bus0.stop_n, tbl[j].stop);
    end

    // dut1 (DEB 2): two-cycle taps land an event every 4 cycles, inside each load phase.
    for (int p = 0; p < 3; p++) begin
      cyc(1, 1, 1, 0, 1);
      cyc(1, 1, 1, 0, 1);
      cyc(1, 1, 1, 1, 1);
      if (p == 2) begin
        chk("abort.pre_mode", bus1.mode, 2);
        chk("abort.pre_S1S0", {bus1.S1, bus1.S0}, 3);
      end
      cyc(1, 1, 1, 1, 1);
      chk($sformatf("abort%0d.mode", p), bus1.mode, p + 1);
      chk($sformatf("abort%0d.S1S0", p), {bus1.S1, bus1.S0}, (p == 2) ? 0 : 3);
      chk($sformatf("abort%0d.D", p), bus1.D, (p == 0) ? 8'h01 : (p == 1) ? 8'h80 : 8'h00);
    end

    for (int k = 0; k < 4; k++) rk[k] = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 4) == 0) rk[k] = !rk[k];
      cyc(($urandom_range(0, 499) != 0), rk[0], rk[1], rk[2], rk[3]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 Parameter DEB_CNT, default 1_000_000, debounce window in clk cycles (20 ms at 50 MHz).
REQ-002 Parameter LOAD_CNT, default 50_000_000, load-phase length in clk cycles (one 1 Hz period at 50 MHz).
REQ-003 clk  input  1  system clock; the only clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 key_mode_n  input  1  raw mode push-button, active-low, asynchronous to clk.
REQ-006 key_pause_n  input  1  raw pause push-button, active-low, asynchronous to clk.
REQ-007 S  output  1  waterfall mux select: 1 = decoder path, 0 = shift-register path.
REQ-008 S1, S0  output  1 each  shift-register mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-009 D  output  8  shift-register parallel-load pattern.
REQ-010 stop_n  output  1  counter run enable: 1 = run, 0 = frozen.
REQ-011 mode  output  2  current mode code, for status LEDs.

Function
REQ-012 Each key SHALL pass through a 2-FF synchronizer before any other logic.
REQ-013 Debounce: the synchronized level SHALL be accepted only after it has been stable for DEB_CNT consecutive cycles; any change restarts the count.
REQ-014 A press event SHALL be a one-cycle pulse on the accepted 1->0 transition; releases and bounces SHALL generate nothing.
REQ-015 Mode FSM states: DEC(0), SHL(1), SHR(2), HOLD(3); each mode press advances the FSM DEC->SHL->SHR->HOLD->DEC.
REQ-016 On entry to SHL or SHR, a load phase SHALL run for LOAD_CNT cycles with S1S0=11, then the FSM SHALL switch to the shift code (SHL 10, SHR 01).
REQ-017 D SHALL be 8'h01 in SHL, 8'h80 in SHR, and 8'h00 in DEC and HOLD.
REQ-018 S SHALL be 1 in DEC and 0 in SHL, SHR, and HOLD; S1S0 SHALL be 00 in DEC and HOLD.
REQ-019 A pause press SHALL toggle an internal paused flag; paused=1 SHALL force stop_n=0 in DEC and S1S0=00 in SHL/SHR once the load phase has ended.
REQ-020 Paused SHALL NOT suspend or shorten a load phase; the load phase always completes its LOAD_CNT cycles.
REQ-021 A mode press SHALL clear paused in the same cycle as the state change.
REQ-022 A mode press during a load phase SHALL abort the phase and advance the FSM immediately.
REQ-023 On SHR->HOLD the register keeps its contents (S1S0=00); no reload SHALL occur.
REQ-024 Simultaneous mode and pause events in one cycle: the mode event wins, and paused ends at 0.
REQ-025 stop_n SHALL be 1 in SHL, SHR, and HOLD.
REQ-026 All outputs SHALL be registered: an event in cycle n is visible at the outputs in cycle n+1.
REQ-027 mode SHALL equal the FSM state code.

Reset
REQ-028 While rst_n=0 at a clk edge: state DEC, paused=0, debounce and load counters 0, accepted key levels 1.
REQ-029 Outputs SHALL then be: S=1, S1S0=00, D=00, stop_n=1, mode=0.
REQ-030 Reset asserted mid-load-phase or mid-debounce SHALL discard that activity; no press event SHALL follow reset release while the keys are held high.

Verification (use DEB_CNT=4, LOAD_CNT=8)
REQ-031 Press mode, clean, for 10 cycles -> exactly one event; mode=1, S=0, S1S0=11, D=01 for 8 cycles, then S1S0=10.
REQ-032 Bounce pattern 0,1,0,1 then stable 0 -> exactly one event, issued 4 cycles after the last edge; a glitch shorter than 4 cycles -> no event.
REQ-033 In DEC, press pause -> stop_n=0; press pause again -> stop_n=1; press mode while paused -> mode=1 and paused cleared.
REQ-034 In SHR, press mode at load cycle 3 -> mode=3 next cycle, S1S0=00, D=00.
REQ-035 Mode and pause events in the same cycle in SHL -> mode=2, load phase starts, stop_n=1, paused=0.
REQ-036 Assert rst_n=0 for 1 cycle during a SHL load phase -> next cycle all reset values from REQ-029; no spurious event after release.
